// File: rtl/jtframe_cen_gen_if.sv
// Configuration and output bundle for jtframe_cen_gen.
// cfg_we is a single-cycle valid strobe; the generator is always ready, so no ready signal exists.
interface jtframe_cen_gen_if #(
    parameter int CH = 3,
    parameter int W  = 10
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    logic           locked;
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [W-1:0]   cfg_num;
    logic [W-1:0]   cfg_den;
    logic [CH-1:0]  cen;
    logic           rst_out_n;
    logic           running;
    logic [1:0]     dbg_state;

    modport master (
        output locked, cfg_we, cfg_ch, cfg_num, cfg_den,
        input  cen, rst_out_n, running, dbg_state
    );

    modport slave (
        input  locked, cfg_we, cfg_ch, cfg_num, cfg_den,
        output cen, rst_out_n, running, dbg_state
    );
endinterface

// File: rtl/jtframe_cen_gen.sv
// Fractional clock-enable generator with per-channel num/den ratios, gated by a
// synchronised PLL lock that also sequences the core reset.
module jtframe_cen_gen #(
    parameter int              CH      = 3,
    parameter int              W       = 10,
    parameter logic [CH*W-1:0] DEF_NUM = {10'd1, 10'd1, 10'd1},
    parameter logic [CH*W-1:0] DEF_DEN = {10'd16, 10'd4, 10'd2},
    parameter int              SETTLE  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    jtframe_cen_gen_if.slave  bus
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int SW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [1:0]    sync_q;
    logic          lk_s;
    logic          running_q;
    logic          active;

    logic [W-1:0]  num_q [CH];
    logic [W-1:0]  num_d [CH];
    logic [W-1:0]  den_q [CH];
    logic [W-1:0]  den_d [CH];
    logic [W:0]    acc_q [CH];
    logic [W:0]    acc_d [CH];
    logic [CH-1:0] cen_q, cen_d;
    logic [W:0]    sum;

    assign lk_s = sync_q[1];
    // Accumulation begins one edge after running rises, so the first RUN edge never pulses.
    assign active = (state_q == ST_RUN) && running_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            ST_WAIT: begin
                if (lk_s) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!lk_s)                      state_d = ST_WAIT;
                else if (cnt_q == SETTLE_LAST)  state_d = ST_RUN;
                else                            cnt_d = cnt_q + SW'(1);
            end
            ST_RUN: begin
                if (!lk_s) state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        sum   = '0;
        cen_d = '0;
        for (int c = 0; c < CH; c++) begin
            num_d[c] = num_q[c];
            den_d[c] = den_q[c];
            acc_d[c] = '0;
            if (bus.cfg_we && (bus.cfg_ch == CHW'(c))) begin
                num_d[c] = bus.cfg_num;
                den_d[c] = bus.cfg_den;
            end else if (active && (num_q[c] != '0) && (den_q[c] != '0)) begin
                if (num_q[c] >= den_q[c]) begin
                    cen_d[c] = 1'b1;
                end else begin
                    sum = acc_q[c] + {1'b0, num_q[c]};
                    if (sum >= {1'b0, den_q[c]}) begin
                        acc_d[c] = sum - {1'b0, den_q[c]};
                        cen_d[c] = 1'b1;
                    end else begin
                        acc_d[c] = sum;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_WAIT;
            cnt_q     <= '0;
            sync_q    <= '0;
            running_q <= 1'b0;
            cen_q     <= '0;
            for (int c = 0; c < CH; c++) begin
                num_q[c] <= DEF_NUM[c*W +: W];
                den_q[c] <= DEF_DEN[c*W +: W];
                acc_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync_q    <= {sync_q[0], bus.locked};
            running_q <= (state_q == ST_RUN);
            cen_q     <= cen_d;
            for (int c = 0; c < CH; c++) begin
                num_q[c] <= num_d[c];
                den_q[c] <= den_d[c];
                acc_q[c] <= acc_d[c];
            end
        end
    end

    assign bus.cen       = cen_q;
    assign bus.running   = running_q;
    assign bus.rst_out_n = running_q;
    assign bus.dbg_state = state_q;
endmodule
